// File: rtl/syn_downcounter_prog.sv
// Programmable down counter/timer with one-shot and auto-reload modes.
// Define DOWNCNT_PRESCALE_EN to decrement only every PRESCALE-th enabled cycle.
module syn_downcounter_prog #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
        $error("PRESCALE must lie in 2..256");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             run_en;
    logic             step;

    assign run_en = (state_q == S_RUN) && en;

`ifdef DOWNCNT_PRESCALE_EN
    localparam int unsigned   PS_W   = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] pre_q, pre_d;

    assign step = run_en && (pre_q == PS_MAX);

    // Prescaler wraps to zero on the stepping edge, so entering DONE leaves it clear.
    always_comb begin
        pre_d = pre_q;
        if (load) begin
            pre_d = '0;
        end else if (run_en) begin
            pre_d = step ? '0 : pre_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pre_q <= '0;
        else        pre_q <= pre_d;
    end
`else
    assign step = run_en;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_RUN: begin
                    if (step) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else begin
                            tc_d = 1'b1;
                            if (mode) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DONE:  count_d = '0;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_syn_downcounter_prog.sv
// Scoreboard bench for syn_downcounter_prog: stimulus pushes expected outputs,
// a monitor pops and compares one vector per clock.
`timescale 1ns/1ps
module tb_syn_downcounter_prog;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned PRESCALE = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    syn_downcounter_prog #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int cnt;
        bit tc;
        bit busy;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: phase 0 = idle, 1 = running, 2 = finished
    int m_cnt = 0, m_reload = 0, m_phase = 0, m_pre = 0;
    bit m_tc = 0;

    function automatic int ticks_per_step();
`ifdef DOWNCNT_PRESCALE_EN
        return PRESCALE;
`else
        return 1;
`endif
    endfunction

    function automatic void model_edge(bit rst_n, bit l, int lv, bit e, bit m);
        m_tc = 0;
        if (!rst_n) begin
            m_cnt = 0; m_reload = 0; m_phase = 0; m_pre = 0;
        end else if (l) begin
            m_cnt = lv; m_reload = lv; m_pre = 0;
            m_phase = (lv != 0) ? 1 : 0;
        end else if (m_phase == 1 && e) begin
            m_pre++;
            if (m_pre == ticks_per_step()) begin
                m_pre = 0;
                if (m_cnt > 1) m_cnt--;
                else begin
                    m_tc = 1;
                    if (m) m_cnt = m_reload;
                    else begin m_cnt = 0; m_phase = 2; end
                end
            end
        end else if (m_phase == 2) begin
            m_cnt = 0;
        end
    endfunction

    function automatic void compare(string name, exp_t e);
        n_vec++;
        if (int'(count) != e.cnt || tc !== e.tc || busy !== e.busy || done !== e.done) begin
            n_err++;
            $display("FAIL %s t=%0t: got count=%0d tc=%b busy=%b done=%b, expected count=%0d tc=%b busy=%b done=%b",
                     name, $time, count, tc, busy, done, e.cnt, e.tc, e.busy, e.done);
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.cnt  = m_cnt;
        e.tc   = m_tc;
        e.busy = (m_phase == 1);
        e.done = (m_phase == 2);
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) compare("edge", exp_q.pop_front());
    end

    task automatic step(bit rst_n, bit l, int lv, bit e, bit m);
        @(negedge clk);
        reset    = rst_n;
        load     = l;
        load_val = WIDTH'(lv);
        en       = e;
        mode     = m;
        model_edge(rst_n, l, lv, e, m);
        exp_q.push_back(model_out());
    endtask

    // Reset asserted between edges must clear outputs without a clock
    task automatic mid_reset();
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_edge(1'b0, 1'b0, 0, 1'b0, 1'b0);
        compare("async_reset", model_out());
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'hA; mode = 1'b0;
        #1;
        model_edge(1'b0, 1'b0, 0, 1'b0, 1'b0);
        compare("reset_state", model_out());
        repeat (9) step(0, 1, 'hA, 0, 0);
        step(1, 1, 'hA, 0, 0);

        step(1, 1, 5, 1, 0);
        repeat (10 * ticks_per_step()) step(1, 0, 0, 1, 0);

        step(1, 1, 3, 1, 1);
        repeat (10 * ticks_per_step()) step(1, 0, 0, 1, 1);

        step(1, 1, 'hF, 0, 0);
        for (int i = 0; i < 34 * int'(ticks_per_step()); i++) step(1, 0, 0, (i % 2) == 0, 0);

        step(1, 1, 2, 1, 0);
        repeat (ticks_per_step()) step(1, 0, 0, 1, 0);
        repeat (ticks_per_step() - 1) step(1, 0, 0, 1, 0);
        step(1, 1, 7, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0);

        step(1, 1, 1, 1, 1);
        repeat (3 * ticks_per_step()) step(1, 0, 0, 1, 1);

        step(1, 1, 9, 1, 0);
        repeat (3) step(1, 0, 0, 1, 0);
        mid_reset();
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            step(1, ($urandom_range(0, 11) == 0), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 199) == 0) mid_reset();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
